// File: rtl/regfile_ctrl_pkg.sv
// Shared types and defaults for the register-file write-back arbiter.
// The write port of the register file is owned by regfile_wb_arbiter.
package regfile_ctrl_pkg;

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   localparam int DEF_ADDR_W   = 5;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_REGS = 32;
   localparam int REG_ZERO     = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first valid requester at or above rr_ptr wins.
// The search wraps around from the highest requester back to requester 0.
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         valid,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] winner,
   output logic                       any_valid
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] rot_valid;
   logic [NUM_REQ-1:0] rot_gnt;
   logic [NUM_REQ:0]   seen;
   logic [IDX_W-1:0]   enc [NUM_REQ+1];

   // Rotate so rr_ptr sits at bit 0, pick the lowest set bit, rotate back.
   assign rot_valid = NUM_REQ'({valid, valid} >> rr_ptr);
   assign seen[0]   = 1'b0;
   assign enc[0]    = '0;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_pri
         assign rot_gnt[gi]  = rot_valid[gi] & ~seen[gi];
         assign seen[gi+1]   = seen[gi] | rot_valid[gi];
         assign enc[gi+1]    = enc[gi] | (grant[gi] ? IDX_W'(gi) : '0);
      end
   endgenerate

   assign grant     = NUM_REQ'(({rot_gnt, rot_gnt} << rr_ptr) >> NUM_REQ);
   assign winner    = enc[NUM_REQ];
   assign any_valid = seen[NUM_REQ];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: round-robin write-back arbitration plus a zero-fill sweep.
// Write-port outputs are registered so they are stable before the register file's negedge sample.
module regfile_wb_arbiter
   import regfile_ctrl_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int NUM_REGS   = DEF_NUM_REGS,
   parameter bit INIT_CLEAR = 1'b1
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      clear_req,
   output logic                      wr_en,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic [DATA_W-1:0]         wr_data,
   output logic                      init_busy
);

   localparam int     IDX_W     = $clog2(NUM_REQ);
   localparam int     CNT_W     = $clog2(NUM_REGS) + 1;
   localparam state_t RST_STATE = INIT_CLEAR ? S_CLEAR : S_RUN;

   state_t             state_reg;
   logic [CNT_W-1:0]   clr_cnt_reg;
   logic [IDX_W-1:0]   rr_ptr_reg;
   logic [IDX_W-1:0]   rr_ptr_next;
   logic               wr_en_reg;
   logic [ADDR_W-1:0]  wr_addr_reg;
   logic [DATA_W-1:0]  wr_data_reg;
   logic               init_busy_reg;

   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   winner;
   logic               any_valid;
   logic               run_ok;
   logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
   logic [DATA_W-1:0]  data_arr [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
         assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .valid     (req_valid),
      .rr_ptr    (rr_ptr_reg),
      .grant     (grant),
      .winner    (winner),
      .any_valid (any_valid)
   );

   // A clear request in RUN takes priority over every write-back requester.
   assign run_ok      = (state_reg == S_RUN) && !clear_req;
   assign req_ready   = run_ok ? grant : '0;
   assign rr_ptr_next = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg     <= RST_STATE;
         init_busy_reg <= INIT_CLEAR;
         clr_cnt_reg   <= '0;
         rr_ptr_reg    <= '0;
         wr_en_reg     <= 1'b0;
         wr_addr_reg   <= '0;
         wr_data_reg   <= '0;
      end else begin
         case (state_reg)
            S_CLEAR: begin
               wr_en_reg   <= 1'b1;
               wr_addr_reg <= ADDR_W'(clr_cnt_reg);
               wr_data_reg <= '0;
               if (clr_cnt_reg == CNT_W'(NUM_REGS - 1)) begin
                  state_reg     <= S_RUN;
                  clr_cnt_reg   <= '0;
                  init_busy_reg <= 1'b0;
               end else begin
                  clr_cnt_reg <= clr_cnt_reg + 1'b1;
               end
            end
            S_RUN: begin
               if (clear_req) begin
                  state_reg     <= S_CLEAR;
                  clr_cnt_reg   <= '0;
                  init_busy_reg <= 1'b1;
                  wr_en_reg     <= 1'b0;
               end else if (any_valid) begin
                  // Writes to the hardwired-zero register are consumed but never issued.
                  rr_ptr_reg  <= rr_ptr_next;
                  wr_en_reg   <= (addr_arr[winner] != ADDR_W'(REG_ZERO));
                  wr_addr_reg <= addr_arr[winner];
                  wr_data_reg <= data_arr[winner];
               end else begin
                  wr_en_reg <= 1'b0;
               end
            end
            default: begin
               state_reg <= RST_STATE;
               wr_en_reg <= 1'b0;
            end
         endcase
      end
   end

   assign wr_en     = wr_en_reg;
   assign wr_addr   = wr_addr_reg;
   assign wr_data   = wr_data_reg;
   assign init_busy = init_busy_reg;

endmodule
